pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: memory busywait, taken-branch flush, load-use bubble.
// Define HAZARD_STATS_EN to add saturating STALL_COUNT / FLUSH_COUNT outputs.
module pipeline_hazard_ctrl (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IMEM_BUSYWAIT,
  input  logic       DMEM_BUSYWAIT,
  input  logic       BRANCH_TAKEN,
  input  logic [4:0] ID_RS1,
  input  logic [4:0] ID_RS2,
  input  logic       ID_RS1_USED,
  input  logic       ID_RS2_USED,
  input  logic [4:0] EX_RD,
  input  logic       EX_MEM_READ,
  input  logic       EX_REG_WRITE_EN,
  output logic       PC_HOLD,
  output logic       IF_ID_HOLD,
  output logic       ID_EX_HOLD,
  output logic       EX_MEM_HOLD,
  output logic       MEM_WB_HOLD,
  output logic       IF_ID_FLUSH,
  output logic       ID_EX_FLUSH
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] STALL_COUNT,
  output logic [15:0] FLUSH_COUNT
`endif
);

  typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT} state_t;

  state_t state_reg, state_next;
  logic   pend_flush_reg, pend_flush_next;
  logic   busy, flush_req, load_use;

  assign busy      = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
  assign flush_req = BRANCH_TAKEN | pend_flush_reg;
  assign load_use  = EX_MEM_READ & EX_REG_WRITE_EN & (EX_RD != 5'd0) &
                     ((ID_RS1_USED & (ID_RS1 == EX_RD)) | (ID_RS2_USED & (ID_RS2 == EX_RD)));

  always_comb begin
    PC_HOLD         = 1'b0;
    IF_ID_HOLD      = 1'b0;
    ID_EX_HOLD      = 1'b0;
    EX_MEM_HOLD     = 1'b0;
    MEM_WB_HOLD     = 1'b0;
    IF_ID_FLUSH     = 1'b0;
    ID_EX_FLUSH     = 1'b0;
    state_next      = RUN;
    pend_flush_next = pend_flush_reg;
    if (busy) begin
      // A branch resolved while frozen is remembered and squashes once memory is ready
      PC_HOLD         = 1'b1;
      IF_ID_HOLD      = 1'b1;
      ID_EX_HOLD      = 1'b1;
      EX_MEM_HOLD     = 1'b1;
      MEM_WB_HOLD     = 1'b1;
      state_next      = MEM_WAIT;
      pend_flush_next = pend_flush_reg | BRANCH_TAKEN;
    end else if (flush_req) begin
      IF_ID_FLUSH     = 1'b1;
      ID_EX_FLUSH     = 1'b1;
      pend_flush_next = 1'b0;
    end else if (load_use && state_reg != LD_STALL) begin
      PC_HOLD     = 1'b1;
      IF_ID_HOLD  = 1'b1;
      ID_EX_FLUSH = 1'b1;
      state_next  = LD_STALL;
    end
    if (!RESET) begin
      PC_HOLD     = 1'b0;
      IF_ID_HOLD  = 1'b0;
      ID_EX_HOLD  = 1'b0;
      EX_MEM_HOLD = 1'b0;
      MEM_WB_HOLD = 1'b0;
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg      <= RUN;
      pend_flush_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_flush_reg <= pend_flush_next;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [1:0] cnt_inc;
  assign cnt_inc = {IF_ID_FLUSH & RESET, PC_HOLD};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
          cnt_reg <= 16'd0;
        else if (cnt_inc[gi] && cnt_reg != 16'hFFFF)
          cnt_reg <= cnt_reg + 16'd1;
      end
    end
  endgenerate

  assign STALL_COUNT = g_cnt[0].cnt_reg;
  assign FLUSH_COUNT = g_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    bit         imem;
    bit         dmem;
    bit         br;
    logic [4:0] rs1;
    logic [4:0] rs2;
    bit         u1;
    bit         u2;
    logic [4:0] rd;
    bit         mr;
    bit         we;
  } stim_t;

  logic       CLK, RESET;
  logic       IMEM_BUSYWAIT, DMEM_BUSYWAIT, BRANCH_TAKEN;
  logic [4:0] ID_RS1, ID_RS2, EX_RD;
  logic       ID_RS1_USED, ID_RS2_USED, EX_MEM_READ, EX_REG_WRITE_EN;
  logic       PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD, IF_ID_FLUSH, ID_EX_FLUSH;
`ifdef HAZARD_STATS_EN
  logic [15:0] STALL_COUNT, FLUSH_COUNT;
`endif

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .BRANCH_TAKEN(BRANCH_TAKEN),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .EX_REG_WRITE_EN(EX_REG_WRITE_EN),
    .PC_HOLD(PC_HOLD), .IF_ID_HOLD(IF_ID_HOLD), .ID_EX_HOLD(ID_EX_HOLD),
    .EX_MEM_HOLD(EX_MEM_HOLD), .MEM_WB_HOLD(MEM_WB_HOLD),
    .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH)
`ifdef HAZARD_STATS_EN
    , .STALL_COUNT(STALL_COUNT), .FLUSH_COUNT(FLUSH_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB holds, IF_ID flush, ID_EX flush}
  logic [6:0] outs;
  assign outs = {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD, IF_ID_FLUSH, ID_EX_FLUSH};

  int total = 0;
  int bad   = 0;

  // Reference model: "a branch is still owed a squash" and "the previous cycle already took a bubble"
  bit owed_flush = 0;
  bit just_bubbled = 0;
  int m_stall = 0;
  int m_flush = 0;

  localparam stim_t QUIET = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t mk(bit imem, bit dmem, bit br, int rs1, int rs2, bit u1, bit u2,
                               int rd, bit mr, bit we);
    stim_t s;
    s.imem = imem; s.dmem = dmem; s.br = br;
    s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.u1 = u1; s.u2 = u2;
    s.rd = 5'(rd); s.mr = mr; s.we = we;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    IMEM_BUSYWAIT = s.imem; DMEM_BUSYWAIT = s.dmem; BRANCH_TAKEN = s.br;
    ID_RS1 = s.rs1; ID_RS2 = s.rs2; ID_RS1_USED = s.u1; ID_RS2_USED = s.u2;
    EX_RD = s.rd; EX_MEM_READ = s.mr; EX_REG_WRITE_EN = s.we;
  endtask

  task automatic check_counts();
`ifdef HAZARD_STATS_EN
    check_eq("stall_cnt", 32'(STALL_COUNT), m_stall);
    check_eq("flush_cnt", 32'(FLUSH_COUNT), m_flush);
`endif
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance the model at posedge.
  task automatic step(input string tag, input stim_t s, input int want);
    bit busy, lu, reads_rd;
    logic [6:0] exp;
    @(negedge CLK);
    drive(s);
    #1;
    busy = s.imem || s.dmem;
    reads_rd = (s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd);
    lu = s.mr && s.we && s.rd != 0 && reads_rd;
    if (busy)                         exp = 7'b1111100;
    else if (s.br || owed_flush)      exp = 7'b0000011;
    else if (lu && !just_bubbled)     exp = 7'b1100001;
    else                              exp = 7'b0000000;
    check_eq(tag, 32'(outs), 32'(exp));
    if (want >= 0) check_eq({tag, "_fixed"}, 32'(outs), want);
    check_counts();
    @(posedge CLK);
    if (exp[6] && m_stall < 65535) m_stall++;
    if (exp[1] && m_flush < 65535) m_flush++;
    if (busy) begin
      owed_flush = owed_flush || s.br;
      just_bubbled = 0;
    end else if (s.br || owed_flush) begin
      owed_flush = 0;
      just_bubbled = 0;
    end else begin
      just_bubbled = lu && !just_bubbled;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    RESET = 1'b0;
    drive(QUIET);
    owed_flush = 0; just_bubbled = 0; m_stall = 0; m_flush = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq("rst_outs", 32'(outs), 32'h03);
      check_counts();
      @(negedge CLK);
    end
    RESET = 1'b1;
  endtask

  initial begin
    stim_t s;
    RESET = 1'b0;
    drive(QUIET);

    do_reset(5);
    step("post_rst", QUIET, 0);

    // Load-use on rs2: one bubble, then suppressed
    s = mk(0, 0, 0, 1, 5, 0, 1, 5, 1, 1);
    step("lu_stall", s, 7'b1100001);
    step("lu_after", s, 0);
    step("lu_quiet", QUIET, 0);
    s = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    step("lu_rd0", s, 0);

    // Busywait with branch mid-wait -> one deferred flush
    step("bw1", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 7'b1111100);
    step("bw2", mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 7'b1111100);
    step("bw3", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 7'b1111100);
    step("bw_flush", QUIET, 7'b0000011);
    step("bw_done", QUIET, 0);

    // Branch beats load-use, and no bubble-suppression follows
    s = mk(0, 0, 1, 7, 0, 1, 0, 7, 1, 1);
    step("br_lu", s, 7'b0000011);
    s.br = 0;
    step("lu_after_br", s, 7'b1100001);
    step("lu_after_br2", s, 0);

    // Reset in the middle of a wait with a pending flush discards it
    step("bw_pend", mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 7'b1111100);
    do_reset(2);
    step("rst_discard", QUIET, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        s.imem = $urandom_range(0, 9) == 0;
        s.dmem = $urandom_range(0, 9) == 0;
        s.br   = $urandom_range(0, 7) == 0;
        s.rs1  = 5'($urandom_range(0, 3));
        s.rs2  = 5'($urandom_range(0, 3));
        s.u1   = 1'($urandom_range(0, 1));
        s.u2   = 1'($urandom_range(0, 1));
        s.rd   = 5'($urandom_range(0, 3));
        s.mr   = $urandom_range(0, 2) != 0;
        s.we   = $urandom_range(0, 3) != 0;
        step("rand", s, -1);
      end
    end

`ifdef HAZARD_STATS_EN
    do_reset(1);
    s = mk(0, 0, 0, 3, 0, 1, 0, 3, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step("st_lu", s, 7'b1100001);
      step("st_q", QUIET, 0);
    end
    for (int i = 0; i < 2; i++) begin
      step("st_br", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 7'b0000011);
      step("st_q2", QUIET, 0);
    end
    check_eq("stall4", 32'(STALL_COUNT), 4);
    check_eq("flush2", 32'(FLUSH_COUNT), 2);
    for (int i = 0; i < 70000; i++)
      step("sat", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), -1);
    step("sat_end", QUIET, 0);
    check_eq("stall_sat", 32'(STALL_COUNT), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
